// File: rtl/keypad_calc_pkg.sv
// Purpose: shared types and constants for the keypad calculator datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: ALU op encoding, sequencer states, scan-result type with its
// "no key" sentinel, column drive after reset, lowest-row priority helper.
package keypad_calc_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_MUL = 3'd6,
    OP_CMP = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Result of (part of) one keypad scan: vld=0 means nothing pressed so far.
  typedef struct packed {
    logic       vld;
    logic [3:0] code;   // {row_idx, col_idx}
  } scan_key_t;

  localparam scan_key_t  KEY_NONE  = 5'b0_0000;
  localparam logic [3:0] COL_RESET = 4'b0001;

  // Lowest set row index wins when several rows are high.
  function automatic logic [1:0] low_row_idx(input logic [3:0] rows);
    low_row_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rows[i]) low_row_idx = 2'(i);
    end
  endfunction

endpackage

// File: rtl/keypad_calc_core_scanner.sv
// Purpose: 4x4 keypad column scanner with full-scan debounce and release lockout.
// Latency: key_valid DEB_SCANS full scans after a stable press (+/- one dwell).
// Backpressure: none; key_valid is a one-cycle pulse that must be taken when seen.
// Ports: i_clk/i_reset (sync, active-high); i_row_in rows in; o_col_out one-hot
// column drive; o_key_valid accept pulse; o_key_code {row,col} of last accepted key.
module keypad_scanner
  import keypad_calc_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int DEB_SCANS = 3
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [3:0] i_row_in,
  output logic [3:0] o_col_out,
  output logic       o_key_valid,
  output logic [3:0] o_key_code
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEB_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ACCEPT = CNT_W'(DEB_SCANS);

  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_col;
  scan_key_t        r_scan;     // first key found so far in the current scan
  logic [3:0]       r_cand;     // key being debounced
  logic [CNT_W-1:0] r_cnt;      // consecutive scans that reported r_cand
  logic             r_locked;   // r_cand already accepted, waiting for release
  logic             r_key_valid;
  logic [3:0]       r_key_code;

  logic             w_last;
  logic             w_scan_done;
  logic             w_same;
  logic             w_accept;
  scan_key_t        w_col_key;
  scan_key_t        w_scan_now;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_comb begin
    w_last         = (r_div == DIV_LAST);
    w_scan_done    = w_last && (r_col == 2'd3);
    w_col_key      = KEY_NONE;
    w_col_key.vld  = |i_row_in;
    w_col_key.code = {low_row_idx(i_row_in), r_col};
    // An earlier column in this scan keeps priority over later ones.
    w_scan_now     = r_scan.vld ? r_scan : w_col_key;
    w_same         = (r_cnt != '0) && (w_scan_now.code == r_cand);
    w_cnt_nxt      = w_same ? (r_cnt + CNT_W'(1)) : CNT_W'(1);
    w_accept       = w_scan_now.vld && !(w_same && r_locked) && (w_cnt_nxt == CNT_ACCEPT);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_div       <= '0;
      r_col       <= 2'd0;
      r_scan      <= KEY_NONE;
      r_cand      <= 4'h0;
      r_cnt       <= '0;
      r_locked    <= 1'b0;
      r_key_valid <= 1'b0;
      r_key_code  <= 4'h0;
    end else begin
      r_key_valid <= 1'b0;
      if (w_last) begin
        r_div  <= '0;
        r_col  <= r_col + 2'd1;
        r_scan <= w_scan_done ? KEY_NONE : w_scan_now;
      end else begin
        r_div  <= r_div + DIV_W'(1);
      end

      if (w_scan_done) begin
        if (!w_scan_now.vld) begin
          // A full empty scan is the release.
          r_cnt    <= '0;
          r_locked <= 1'b0;
        end else if (!(w_same && r_locked)) begin
          // A new key (or still-debouncing same key) advances or restarts the count.
          r_cand   <= w_scan_now.code;
          r_cnt    <= w_cnt_nxt;
          r_locked <= w_accept;
          if (w_accept) begin
            r_key_valid <= 1'b1;
            r_key_code  <= w_scan_now.code;
          end
        end
      end
    end
  end

  assign o_col_out   = COL_RESET << r_col;
  assign o_key_valid = r_key_valid;
  assign o_key_code  = r_key_code;

endmodule

// File: rtl/keypad_calc_core.sv
// Purpose: keypad digit entry, NREGS register file and 8-op ALU under a sequencer.
// Latency: single-cycle ops 2 edges start->result, MUL DATA_W+1 edges.
// Backpressure: start is accepted only in IDLE (busy low); otherwise ignored.
// Ports: i_clk/i_reset; i_row_in/o_col_out keypad pins; o_key_valid/o_key_code/o_entry
// entry path; i_wr_en/i_wr_addr commit; i_addr_a/i_addr_b/i_op/i_start launch;
// o_busy, o_result, o_result_valid, o_carry, o_zero results and flags.
module keypad_calc_core
  import keypad_calc_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NREGS     = 4,
  parameter int SCAN_DIV  = 1000,
  parameter int DEB_SCANS = 3
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [3:0]               i_row_in,
  output logic [3:0]               o_col_out,
  output logic                     o_key_valid,
  output logic [3:0]               o_key_code,
  output logic [DATA_W-1:0]        o_entry,
  input  logic                     i_wr_en,
  input  logic [$clog2(NREGS)-1:0] i_wr_addr,
  input  logic [$clog2(NREGS)-1:0] i_addr_a,
  input  logic [$clog2(NREGS)-1:0] i_addr_b,
  input  logic [2:0]               i_op,
  input  logic                     i_start,
  output logic                     o_busy,
  output logic [DATA_W-1:0]        o_result,
  output logic                     o_result_valid,
  output logic                     o_carry,
  output logic                     o_zero
);

  localparam int SH_W   = $clog2(DATA_W);
  localparam int STEP_W = $clog2(DATA_W);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(DATA_W - 1);

  logic                  w_key_valid;
  logic [3:0]            w_key_code;

  logic [DATA_W-1:0]     r_entry;
  logic [DATA_W-1:0]     r_regs [NREGS];
  state_e                r_state;
  state_e                w_state_nxt;
  logic [DATA_W-1:0]     r_a;
  logic [DATA_W-1:0]     r_b;          // also the multiplier, shifted right per step
  op_e                   r_op;
  logic [2*DATA_W-1:0]   r_mcand;      // multiplicand, shifted left per step
  logic [2*DATA_W-1:0]   r_prod;
  logic [STEP_W-1:0]     r_step;
  logic [DATA_W-1:0]     r_result;
  logic                  r_carry;
  logic                  r_zero;

  logic [DATA_W:0]       w_sum;
  logic [DATA_W:0]       w_shl;        // bit DATA_W is the last bit shifted out
  logic [SH_W-1:0]       w_shamt;
  logic [DATA_W-1:0]     w_alu_res;
  logic                  w_alu_carry;
  logic                  w_alu_zero;
  logic [2*DATA_W-1:0]   w_prod_nxt;

  keypad_scanner #(
    .SCAN_DIV  (SCAN_DIV),
    .DEB_SCANS (DEB_SCANS)
  ) u_scanner (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_row_in    (i_row_in),
    .o_col_out   (o_col_out),
    .o_key_valid (w_key_valid),
    .o_key_code  (w_key_code)
  );

  // Entry shifts in digits; a commit clears it, but a digit landing in the
  // same cycle becomes the first digit of the next entry.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_entry <= '0;
    end else if (i_wr_en) begin
      r_entry <= w_key_valid ? DATA_W'(w_key_code) : '0;
    end else if (w_key_valid) begin
      r_entry <= {r_entry[DATA_W-5:0], w_key_code};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (i_wr_en) begin
      r_regs[i_wr_addr] <= r_entry;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_state_nxt = (op_e'(i_op) == OP_MUL) ? ST_MUL : ST_EXEC;
      ST_EXEC: w_state_nxt = ST_DONE;
      ST_MUL:  if (r_step == STEP_LAST) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_alu_res   = '0;
    w_alu_carry = 1'b0;
    w_sum       = {1'b0, r_a} + {1'b0, r_b};
    w_shamt     = r_b[SH_W-1:0];
    w_shl       = {1'b0, r_a} << w_shamt;
    case (r_op)
      OP_ADD: begin w_alu_res = w_sum[DATA_W-1:0]; w_alu_carry = w_sum[DATA_W]; end
      OP_SUB: begin w_alu_res = r_a - r_b;         w_alu_carry = (r_a < r_b);   end
      OP_AND: w_alu_res = r_a & r_b;
      OP_OR:  w_alu_res = r_a | r_b;
      OP_XOR: w_alu_res = r_a ^ r_b;
      OP_SHL: begin
        w_alu_res   = w_shl[DATA_W-1:0];
        w_alu_carry = (w_shamt != '0) && w_shl[DATA_W];
      end
      OP_CMP: w_alu_carry = (r_a < r_b);
      default: w_alu_res = '0;
    endcase
    w_alu_zero = (r_op == OP_CMP) ? (r_a == r_b) : (w_alu_res == '0);
    w_prod_nxt = r_prod + (r_b[0] ? r_mcand : '0);
  end

  // Operands are latched at launch so later register writes cannot disturb
  // an operation in flight.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= OP_ADD;
      r_mcand  <= '0;
      r_prod   <= '0;
      r_step   <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_a     <= r_regs[i_addr_a];
            r_b     <= r_regs[i_addr_b];
            r_op    <= op_e'(i_op);
            r_mcand <= {{DATA_W{1'b0}}, r_regs[i_addr_a]};
            r_prod  <= '0;
            r_step  <= '0;
          end
        end
        ST_EXEC: begin
          r_result <= w_alu_res;
          r_carry  <= w_alu_carry;
          r_zero   <= w_alu_zero;
        end
        ST_MUL: begin
          r_prod  <= w_prod_nxt;
          r_mcand <= r_mcand << 1;
          r_b     <= r_b >> 1;
          r_step  <= r_step + STEP_W'(1);
          if (r_step == STEP_LAST) begin
            r_result <= w_prod_nxt[DATA_W-1:0];
            r_carry  <= |w_prod_nxt[2*DATA_W-1:DATA_W];
            r_zero   <= (w_prod_nxt[DATA_W-1:0] == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_key_valid    = w_key_valid;
  assign o_key_code     = w_key_code;
  assign o_entry        = r_entry;
  assign o_busy         = (r_state != ST_IDLE);
  assign o_result_valid = (r_state == ST_DONE);
  assign o_result       = r_result;
  assign o_carry        = r_carry;
  assign o_zero         = r_zero;

endmodule
